// File: rtl/rnbip_regfile_pkg.sv
// Shared register-file encodings: enable codes, write-source selects,
// decoded op codes and the access sequencer state enum. Imported by the
// register file and by regfile_access_seq.
package rnbip_regfile_pkg;

  // Register-file enable codes
  localparam logic [1:0] ENAB_IDLE = 2'b00;
  localparam logic [1:0] ENAB_WR   = 2'b01;
  localparam logic [1:0] ENAB_RD   = 2'b11;

  // Write-source selects (MUX_NONE whenever no write is in progress)
  localparam logic [2:0] MUX_NONE  = 3'b000;
  localparam logic [2:0] MUX_REG   = 3'b001;
  localparam logic [2:0] MUX_OR    = 3'b010;
  localparam logic [2:0] MUX_ALU   = 3'b011;

  // Decoded register command op codes
  localparam logic [1:0] OP_MOV    = 2'b00;
  localparam logic [1:0] OP_MVI    = 2'b01;
  localparam logic [1:0] OP_ALU    = 2'b10;
  localparam logic [1:0] OP_RD     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } seq_state_e;

  // Write source used by each op when it reaches its write cycle
  function automatic logic [2:0] mux_for_op(input logic [1:0] op);
    logic [2:0] sel;
    case (op)
      OP_MOV:  sel = MUX_REG;
      OP_MVI:  sel = MUX_OR;
      OP_ALU:  sel = MUX_ALU;
      default: sel = MUX_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/regfile_access_seq.sv
// Register-file access sequencer. Takes one decoded command per valid/ready
// handshake and expands it into the READ / EXEC / WRITE / DONE cycles the
// register file expects; ALU ops also handshake with the ALU.
// All outputs come straight from flops: next-cycle output values are
// computed together with the next state and registered alongside it.
// Optional feature macro: REGSEQ_ALU_TIMEOUT_EN (bounds the ALU wait to
// ALU_TIMEOUT EXEC cycles and raises a sticky err on expiry).
module regfile_access_seq
  import rnbip_regfile_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  output logic              alu_start,
  input  logic              alu_done,
  output logic [1:0]        enab,
  output logic [ADDR_W-1:0] seg,
  output logic [2:0]        mux_sel,
  output logic [ADDR_W-1:0] reg_sel,
  output logic              done,
  output logic              err
);

  seq_state_e        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [1:0]        enab_q, enab_d;
  logic [ADDR_W-1:0] seg_q, seg_d;
  logic [2:0]        mux_sel_q, mux_sel_d;
  logic [ADDR_W-1:0] reg_sel_q, reg_sel_d;
  logic              alu_start_q, alu_start_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;

`ifdef REGSEQ_ALU_TIMEOUT_EN
  localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next state plus the output values the next state presents
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    enab_d      = ENAB_IDLE;
    seg_d       = seg_q;
    mux_sel_d   = MUX_NONE;
    reg_sel_d   = reg_sel_q;
    alu_start_d = 1'b0;
    done_d      = 1'b0;
    cmd_ready_d = 1'b0;
`ifdef REGSEQ_ALU_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          dst_d       = cmd_dst;
          cmd_ready_d = 1'b0;
          if (cmd_op == OP_MOV || cmd_op == OP_MVI) begin
            // MOV/MVI need no read phase: go straight to the write cycle
            state_d   = ST_WRITE;
            enab_d    = ENAB_WR;
            seg_d     = cmd_dst;
            mux_sel_d = mux_for_op(cmd_op);
            if (cmd_op == OP_MOV) begin
              reg_sel_d = cmd_src;
            end
          end else begin
            state_d = ST_READ;
            enab_d  = ENAB_RD;
            seg_d   = cmd_src;
          end
        end
      end

      ST_READ: begin
        if (op_q == OP_ALU) begin
          state_d     = ST_EXEC;
          alu_start_d = 1'b1;
`ifdef REGSEQ_ALU_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_EXEC: begin
        // alu_done is honoured even in the cycle alu_start is high
        if (alu_done) begin
          state_d   = ST_WRITE;
          enab_d    = ENAB_WR;
          seg_d     = dst_q;
          mux_sel_d = MUX_ALU;
        end
`ifdef REGSEQ_ALU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // ALU never answered: abandon the write and finish with err set
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MOV;
      dst_q       <= '0;
      enab_q      <= ENAB_IDLE;
      seg_q       <= '0;
      mux_sel_q   <= MUX_NONE;
      reg_sel_q   <= '0;
      alu_start_q <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      enab_q      <= enab_d;
      seg_q       <= seg_d;
      mux_sel_q   <= mux_sel_d;
      reg_sel_q   <= reg_sel_d;
      alu_start_q <= alu_start_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

`ifdef REGSEQ_ALU_TIMEOUT_EN
  // EXEC wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign alu_start = alu_start_q;
  assign enab      = enab_q;
  assign seg       = seg_q;
  assign mux_sel   = mux_sel_q;
  assign reg_sel   = reg_sel_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Self-checking bench for regfile_access_seq. A bench-side register file
// reacts to the DUT's write cycles; a command-level model (register
// contents and latencies from the op rules) provides the expected values.
module tb_regfile_access_seq;
  import rnbip_regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src;
  logic       alu_start;
  logic       alu_done;
  logic [1:0] enab;
  logic [2:0] seg;
  logic [2:0] mux_sel;
  logic [2:0] reg_sel;
  logic       done;
  logic       err;

  regfile_access_seq #(.ADDR_W(3), .ALU_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .alu_start(alu_start), .alu_done(alu_done),
    .enab(enab), .seg(seg), .mux_sel(mux_sel), .reg_sel(reg_sel),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int dst, src, aluDelay, or2, aluIn;
    int expLat, expWrites, expReads, expWrSeg, expMux, expRegSel, expRdSeg;
  } vec_t;

  typedef struct {
    int acc, doneAt, startAt, starts, writes, reads;
    int wrSeg, wrMux, wrRegSel, rdSeg, readyBad, errAtDone, readyAfter, enabAfter;
  } obs_t;

  int checks = 0;
  int errors = 0;
  int errExp = 0;
  logic [7:0] rf    [8];
  logic [7:0] expRf [8];
  logic [7:0] or2Val;
  logic [7:0] aluVal;
  vec_t vecs [9];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // bench register file performs whatever write the DUT requests this cycle
  task automatic modelWrite();
    case (mux_sel)
      MUX_REG: rf[seg] = rf[reg_sel];
      MUX_OR:  rf[seg] = or2Val;
      MUX_ALU: rf[seg] = aluVal;
      default: rf[seg] = 8'hEE;
    endcase
  endtask

  task automatic checkRf(input string name);
    int bad = 0;
    for (int i = 0; i < 8; i++) if (rf[i] !== expRf[i]) bad++;
    checkOutput(name, bad, 0);
  endtask

  // Drives one command and records what the DUT did, cycle by cycle.
  // aluDelay: cycles from alu_start to alu_done (-1 = never).
  task automatic applyStimulus(input logic [1:0] op, input int dst, input int src,
                               input int aluDelay, output obs_t o);
    bit finished = 0;
    o.acc = -1; o.doneAt = -1; o.startAt = -1; o.starts = 0; o.writes = 0; o.reads = 0;
    o.wrSeg = -1; o.wrMux = -1; o.wrRegSel = -1; o.rdSeg = -1; o.readyBad = 0;
    o.errAtDone = -1; o.readyAfter = -1; o.enabAfter = -1;
    @(negedge clk);
    for (int k = 0; k < 200 && !finished; k++) begin
      if (o.acc >= 0 && cmd_ready) o.readyBad++;
      if (enab == ENAB_WR) begin
        o.writes++; o.wrSeg = int'(seg); o.wrMux = int'(mux_sel); o.wrRegSel = int'(reg_sel);
        modelWrite();
      end
      if (enab == ENAB_RD) begin
        o.reads++; o.rdSeg = int'(seg);
      end
      if (alu_start) begin
        o.starts++;
        if (o.startAt < 0) o.startAt = k;
      end
      if (done) begin
        o.doneAt = k; o.errAtDone = int'(err); finished = 1;
      end
      if (finished) begin
        cmd_valid = 1'b0; alu_done = 1'b0;
      end else if (o.acc < 0) begin
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = 3'(dst); cmd_src = 3'(src);
        alu_done = 1'($urandom_range(0, 1));
        if (cmd_ready) o.acc = k;
      end else begin
        // busy: garbage commands must be ignored
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op = 2'($urandom_range(0, 3));
        cmd_dst = 3'($urandom_range(0, 7));
        cmd_src = 3'($urandom_range(0, 7));
        if (o.startAt < 0) alu_done = 1'($urandom_range(0, 1));
        else if (aluDelay >= 0 && k == o.startAt + aluDelay) alu_done = 1'b1;
        else if (aluDelay >= 0 && k > o.startAt + aluDelay) alu_done = 1'($urandom_range(0, 1));
        else alu_done = 1'b0;
      end
      @(negedge clk);
    end
    o.readyAfter = int'(cmd_ready);
    o.enabAfter = int'(enab);
    cmd_valid = 1'b0; alu_done = 1'b0;
  endtask

  // Command-level expectations derived from the op rules
  function automatic vec_t makeVec(input logic [1:0] op, input int dst, input int src,
                                   input int aluDelay, input int or2, input int aluIn);
    vec_t v;
    v.op = op; v.dst = dst; v.src = src; v.aluDelay = aluDelay; v.or2 = or2; v.aluIn = aluIn;
    v.expLat    = (op == OP_ALU) ? aluDelay + 4 : 2;
    v.expWrites = (op == OP_RD) ? 0 : 1;
    v.expReads  = (op == OP_ALU || op == OP_RD) ? 1 : 0;
    v.expWrSeg  = (op == OP_RD) ? -1 : dst;
    v.expMux    = (op == OP_MOV) ? 1 : (op == OP_MVI) ? 2 : (op == OP_ALU) ? 3 : -1;
    v.expRegSel = (op == OP_MOV) ? src : -1;
    v.expRdSeg  = v.expReads ? src : -1;
    return v;
  endfunction

  task automatic runVec(input vec_t v, input string tag);
    obs_t o;
    or2Val = 8'(v.or2);
    aluVal = 8'(v.aluIn);
    case (v.op)
      OP_MOV: expRf[v.dst] = expRf[v.src];
      OP_MVI: expRf[v.dst] = or2Val;
      OP_ALU: if (v.aluDelay >= 0) expRf[v.dst] = aluVal;
      default: ;
    endcase
    applyStimulus(v.op, v.dst, v.src, v.aluDelay, o);
    checkOutput({tag, ".accepted"}, int'(o.acc >= 0), 1);
    checkOutput({tag, ".latency"}, o.doneAt - o.acc, v.expLat);
    checkOutput({tag, ".writes"}, o.writes, v.expWrites);
    checkOutput({tag, ".reads"}, o.reads, v.expReads);
    if (v.expWrites > 0) begin
      checkOutput({tag, ".wrSeg"}, o.wrSeg, v.expWrSeg);
      checkOutput({tag, ".wrMux"}, o.wrMux, v.expMux);
      checkOutput({tag, ".rfDst"}, int'(rf[v.dst]), int'(expRf[v.dst]));
    end
    if (v.expRegSel >= 0) checkOutput({tag, ".regSel"}, o.wrRegSel, v.expRegSel);
    if (v.expReads > 0) checkOutput({tag, ".rdSeg"}, o.rdSeg, v.expRdSeg);
    checkOutput({tag, ".aluStarts"}, o.starts, (v.op == OP_ALU) ? 1 : 0);
    if (v.op == OP_ALU) checkOutput({tag, ".startOffset"}, o.startAt - o.acc, 2);
    checkOutput({tag, ".readyWhileBusy"}, o.readyBad, 0);
    checkOutput({tag, ".readyAfter"}, o.readyAfter, 1);
    checkOutput({tag, ".enabAfter"}, o.enabAfter, 0);
    checkOutput({tag, ".err"}, o.errAtDone, errExp);
    checkRf({tag, ".rf"});
  endtask

  initial begin
    int acc1, acc2, done1, done2, writes, reads, wrSeg, wrMux, rdSeg, seen;
    int wrAfter, doneAfter, notReady;
    bit finished;
    vec_t rv;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0; alu_done = 1'b0;
    or2Val = '0; aluVal = '0;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'($urandom_range(0, 255));
      expRf[i] = rf[i];
    end

    // op, dst, src, aluDelay, or2, aluIn | lat, writes, reads, wrSeg, mux, regSel, rdSeg
    vecs[0] = '{OP_MVI, 2, 0,  0,   5,   0,  2, 1, 0,  2,  2, -1, -1};
    vecs[1] = '{OP_MOV, 0, 2,  0,   0,   0,  2, 1, 0,  0,  1,  2, -1};
    vecs[2] = '{OP_ALU, 7, 2,  4,   0,  60,  8, 1, 1,  7,  3, -1,  2};
    vecs[3] = '{OP_RD,  0, 2,  0,   0,   0,  2, 0, 1, -1, -1, -1,  2};
    vecs[4] = '{OP_ALU, 3, 1,  0,   0, 129,  4, 1, 1,  3,  3, -1,  1};
    vecs[5] = '{OP_MOV, 5, 5,  0,   0,   0,  2, 1, 0,  5,  1,  5, -1};
    vecs[6] = '{OP_MVI, 0, 0,  0, 165,   0,  2, 1, 0,  0,  2, -1, -1};
    vecs[7] = '{OP_ALU, 0, 7, 15,   0,  77, 19, 1, 1,  0,  3, -1,  7};
    vecs[8] = '{OP_ALU, 6, 6,  1,   0, 200,  5, 1, 1,  6,  3, -1,  6};

    repeat (2) @(negedge clk);
    checkOutput("reset.cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset.enab", int'(enab), 0);
    checkOutput("reset.seg", int'(seg), 0);
    checkOutput("reset.mux_sel", int'(mux_sel), 0);
    checkOutput("reset.reg_sel", int'(reg_sel), 0);
    checkOutput("reset.alu_start", int'(alu_start), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.err", int'(err), 0);
    rst = 1'b0;

    // MVI reads back 5 in reg2; MOV copies reg2 into reg0, etc.
    for (int i = 0; i < 9; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // reset while waiting in EXEC: everything back to reset values, no write
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ALU; cmd_src = 3'd3; cmd_dst = 3'd4; alu_done = 1'b0;
    checkOutput("rstMid.accept", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      if (alu_start) seen = 1;
      else @(negedge clk);
    end
    checkOutput("rstMid.reachedExec", seen, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstMid.enab", int'(enab), 0);
    checkOutput("rstMid.seg", int'(seg), 0);
    checkOutput("rstMid.mux_sel", int'(mux_sel), 0);
    checkOutput("rstMid.reg_sel", int'(reg_sel), 0);
    checkOutput("rstMid.alu_start", int'(alu_start), 0);
    checkOutput("rstMid.done", int'(done), 0);
    checkOutput("rstMid.err", int'(err), 0);
    checkOutput("rstMid.cmd_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wrAfter = 0; doneAfter = 0; notReady = 0;
    for (int k = 0; k < 6; k++) begin
      alu_done = 1'b1;
      if (enab == ENAB_WR) begin wrAfter++; modelWrite(); end
      if (done) doneAfter++;
      if (!cmd_ready) notReady++;
      @(negedge clk);
    end
    alu_done = 1'b0;
    checkOutput("rstMid.writesAfter", wrAfter, 0);
    checkOutput("rstMid.doneAfter", doneAfter, 0);
    checkOutput("rstMid.notReadyAfter", notReady, 0);
    checkRf("rstMid.rf");

    // back-to-back: valid held high, RD then MVI
    or2Val = 8'h3B;
    acc1 = -1; acc2 = -1; done1 = -1; done2 = -1;
    writes = 0; reads = 0; wrSeg = -1; wrMux = -1; rdSeg = -1; finished = 0;
    @(negedge clk);
    for (int k = 0; k < 60 && !finished; k++) begin
      if (enab == ENAB_WR) begin
        writes++; wrSeg = int'(seg); wrMux = int'(mux_sel); modelWrite();
      end
      if (enab == ENAB_RD) begin reads++; rdSeg = int'(seg); end
      if (done) begin
        if (done1 < 0) done1 = k;
        else begin done2 = k; finished = 1; end
      end
      if (finished) cmd_valid = 1'b0;
      else if (acc1 < 0) begin
        cmd_valid = 1'b1; cmd_op = OP_RD; cmd_src = 3'd2; cmd_dst = 3'd0;
      end else if (acc2 < 0) begin
        cmd_valid = 1'b1; cmd_op = OP_MVI; cmd_src = 3'd6; cmd_dst = 3'd1;
      end else cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (acc1 < 0) acc1 = k;
        else if (acc2 < 0) acc2 = k;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    expRf[1] = 8'h3B;
    checkOutput("b2b.firstLatency", done1 - acc1, 2);
    checkOutput("b2b.secondAcceptGap", acc2 - done1, 1);
    checkOutput("b2b.secondLatency", done2 - acc2, 2);
    checkOutput("b2b.writes", writes, 1);
    checkOutput("b2b.wrSeg", wrSeg, 1);
    checkOutput("b2b.wrMux", wrMux, 2);
    checkOutput("b2b.reads", reads, 1);
    checkOutput("b2b.rdSeg", rdSeg, 2);
    checkOutput("b2b.reg1", int'(rf[1]), 8'h3B);

    // randomized commands against the command-level model
    for (int i = 0; i < 40; i++) begin
      rv = makeVec(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 6), $urandom_range(0, 255), $urandom_range(0, 255));
      runVec(rv, $sformatf("rand%0d", i));
    end

`ifdef REGSEQ_ALU_TIMEOUT_EN
    begin
      obs_t o;
      aluVal = 8'h99;
      applyStimulus(OP_ALU, 4, 3, -1, o);
      checkOutput("timeout.accepted", int'(o.acc >= 0), 1);
      checkOutput("timeout.execCycles", o.doneAt - o.startAt, 16);
      checkOutput("timeout.latency", o.doneAt - o.acc, 18);
      checkOutput("timeout.writes", o.writes, 0);
      checkOutput("timeout.err", o.errAtDone, 1);
      checkOutput("timeout.readyAfter", o.readyAfter, 1);
      checkRf("timeout.rf");
      errExp = 1;
      runVec(makeVec(OP_MVI, 6, 0, 0, 8'h42, 0), "afterTimeout");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
